ex_stage: RTL and testbench

- Execute stage plus EX/MEM pipeline register of the 5-stage MIPS pipeline.
- Consumes the registered ID/EX outputs and computes the ALU result, branch target, zero flag and destination register, then registers them toward MEM.
- Contains an iterative 32-cycle shift-add multiplier for R-type MUL.
- Raises stall_o while the multiplier is busy so that PC, IF/ID and ID/EX hold.

---
 rtl/ex_stage.sv | 168 ++++++++++++++++
 tb/tb_ex_stage.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// Execute stage and EX/MEM pipeline register of the 5-stage MIPS pipeline.
// Includes an iterative shift-add multiplier that stalls upstream while busy.
module ex_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [DATA_W-1:0] pc_In,
  input  logic              RegDst_In,
  input  logic              ALUSrc_In,
  input  logic              MemtoReg_In,
  input  logic              RegWrite_In,
  input  logic              MemRead_In,
  input  logic              MemWrite_In,
  input  logic              Branch_In,
  input  logic              Jump_In,
  input  logic [1:0]        ALUOp_In,
  input  logic [2:0]        operation_In,
  input  logic [DATA_W-1:0] RD1_In,
  input  logic [DATA_W-1:0] RD2_In,
  input  logic [DATA_W-1:0] extend_immed_In,
  input  logic [4:0]        rt_In,
  input  logic [4:0]        rd_In,
  input  logic [DATA_W-1:0] in_jump_addr,
  output logic [DATA_W-1:0] alu_result_Out,
  output logic [DATA_W-1:0] wdata_Out,
  output logic [4:0]        wreg_Out,
  output logic              zero_Out,
  output logic [DATA_W-1:0] branch_target_Out,
  output logic [DATA_W-1:0] jump_addr_Out,
  output logic              RegWrite_Out,
  output logic              MemtoReg_Out,
  output logic              MemRead_Out,
  output logic              MemWrite_Out,
  output logic              Branch_Out,
  output logic              Jump_Out,
  output logic              stall_o,
  output logic              mul_busy_o
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic {IDLE, MUL_BUSY} state_t;

  state_t state, state_nxt;

  logic signed [DATA_W-1:0] op_a, op_b;
  logic [DATA_W-1:0] alu_res, acc_step, res_nxt, bt_nxt;
  logic [DATA_W-1:0] mcand_p0, mplier_p0, acc_p0;
  logic [CNT_W-1:0]  cnt_p0;
  logic [4:0]        wreg_nxt;
  logic              is_mul, issue, last, bubble;

  function automatic logic [DATA_W-1:0] alu_calc(
    input logic [1:0]               aluop,
    input logic [2:0]               op,
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic signed [DATA_W-1:0] r;
    r = a + b;
    case (aluop)
      2'b01: r = a - b;
      2'b10: begin
        case (op)
          3'b000:  r = a & b;
          3'b001:  r = a | b;
          3'b110:  r = a - b;
          3'b111:  r = (a < b) ? DATA_W'(1) : '0;
          default: r = a + b;
        endcase
      end
      default: r = a + b;
    endcase
    return r;
  endfunction

  assign op_a     = $signed(RD1_In);
  assign op_b     = ALUSrc_In ? $signed(extend_immed_In) : $signed(RD2_In);
  assign alu_res  = alu_calc(ALUOp_In, operation_In, op_a, op_b);
  assign wreg_nxt = RegDst_In ? rd_In : rt_In;
  assign bt_nxt   = pc_In + (extend_immed_In << 2);

  assign is_mul   = (ALUOp_In == 2'b10) && (operation_In == 3'b011);
  assign issue    = (state == IDLE) && is_mul && !flush;
  assign last     = (state == MUL_BUSY) && (cnt_p0 == CNT_LAST);
  // Final iteration's add is folded in combinationally so the result lands on the last busy edge.
  assign acc_step = acc_p0 + (mplier_p0[0] ? mcand_p0 : '0);
  assign res_nxt  = (state == MUL_BUSY) ? acc_step : alu_res;

  assign bubble     = issue || ((state == MUL_BUSY) && !last);
  assign stall_o    = !rst && !flush && bubble;
  assign mul_busy_o = (state == MUL_BUSY);

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:     if (is_mul) state_nxt = MUL_BUSY;
        MUL_BUSY: if (last)   state_nxt = IDLE;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt_p0 <= '0;
    end else begin
      state <= state_nxt;
      if (flush || issue) begin
        cnt_p0 <= '0;
      end else if (state == MUL_BUSY) begin
        cnt_p0 <= cnt_p0 + CNT_W'(1);
      end
    end
  end

  // Multiplier datapath: operands latched at issue, shifted every busy cycle
  always_ff @(posedge clk) begin
    if (issue) begin
      mcand_p0  <= RD1_In;
      mplier_p0 <= op_b;
      acc_p0    <= '0;
    end else if (state == MUL_BUSY) begin
      mcand_p0  <= mcand_p0 << 1;
      mplier_p0 <= mplier_p0 >> 1;
      acc_p0    <= acc_step;
    end
  end

  // EX/MEM register
  always_ff @(posedge clk) begin
    if (rst || flush || bubble) begin
      alu_result_Out    <= '0;
      wdata_Out         <= '0;
      wreg_Out          <= '0;
      zero_Out          <= 1'b0;
      branch_target_Out <= '0;
      jump_addr_Out     <= '0;
      RegWrite_Out      <= 1'b0;
      MemtoReg_Out      <= 1'b0;
      MemRead_Out       <= 1'b0;
      MemWrite_Out      <= 1'b0;
      Branch_Out        <= 1'b0;
      Jump_Out          <= 1'b0;
    end else begin
      alu_result_Out    <= res_nxt;
      wdata_Out         <= RD2_In;
      wreg_Out          <= wreg_nxt;
      zero_Out          <= (res_nxt == '0);
      branch_target_Out <= bt_nxt;
      jump_addr_Out     <= in_jump_addr;
      RegWrite_Out      <= RegWrite_In;
      MemtoReg_Out      <= MemtoReg_In;
      MemRead_Out       <= MemRead_In;
      MemWrite_Out      <= MemWrite_In;
      Branch_Out        <= Branch_In;
      Jump_Out          <= Jump_In;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: directed instructions push expected EX/MEM contents,
// a negedge monitor pops and compares whenever a non-bubble result is presented.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic [31:0] pc_In, RD1_In, RD2_In, extend_immed_In, in_jump_addr;
  logic        RegDst_In, ALUSrc_In, MemtoReg_In, RegWrite_In;
  logic        MemRead_In, MemWrite_In, Branch_In, Jump_In;
  logic [1:0]  ALUOp_In;
  logic [2:0]  operation_In;
  logic [4:0]  rt_In, rd_In;
  logic [31:0] alu_result_Out, wdata_Out, branch_target_Out, jump_addr_Out;
  logic [4:0]  wreg_Out;
  logic        zero_Out, RegWrite_Out, MemtoReg_Out, MemRead_Out;
  logic        MemWrite_Out, Branch_Out, Jump_Out, stall_o, mul_busy_o;

  typedef struct packed {
    logic [31:0] pc, rd1, rd2, imm, ja;
    logic        regdst, alusrc, memtoreg, regwrite, memread, memwrite, branch, jump;
    logic [1:0]  aluop;
    logic [2:0]  op;
    logic [4:0]  rt, rd;
  } in_t;

  typedef struct packed {
    logic [31:0] res, wdata, bt, ja;
    logic [4:0]  wreg;
    logic        zero;
    logic [5:0]  ctl;   // {RegWrite, MemtoReg, MemRead, MemWrite, Branch, Jump}
    int          bub;   // bubbles expected before this result, -1 = don't care
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   bub_cnt  = 0;

  ex_stage #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .pc_In(pc_In),
    .RegDst_In(RegDst_In), .ALUSrc_In(ALUSrc_In), .MemtoReg_In(MemtoReg_In),
    .RegWrite_In(RegWrite_In), .MemRead_In(MemRead_In), .MemWrite_In(MemWrite_In),
    .Branch_In(Branch_In), .Jump_In(Jump_In), .ALUOp_In(ALUOp_In),
    .operation_In(operation_In), .RD1_In(RD1_In), .RD2_In(RD2_In),
    .extend_immed_In(extend_immed_In), .rt_In(rt_In), .rd_In(rd_In),
    .in_jump_addr(in_jump_addr), .alu_result_Out(alu_result_Out),
    .wdata_Out(wdata_Out), .wreg_Out(wreg_Out), .zero_Out(zero_Out),
    .branch_target_Out(branch_target_Out), .jump_addr_Out(jump_addr_Out),
    .RegWrite_Out(RegWrite_Out), .MemtoReg_Out(MemtoReg_Out),
    .MemRead_Out(MemRead_Out), .MemWrite_Out(MemWrite_Out),
    .Branch_Out(Branch_Out), .Jump_Out(Jump_Out),
    .stall_o(stall_o), .mul_busy_o(mul_busy_o)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [31:0] res, wdata, bt, ja, input logic [4:0] wreg,
                              input logic zero, input logic [5:0] ctl, input int bub);
    exp_t e;
    e.res = res; e.wdata = wdata; e.bt = bt; e.ja = ja;
    e.wreg = wreg; e.zero = zero; e.ctl = ctl; e.bub = bub;
    return e;
  endfunction

  task automatic apply(input in_t i);
    pc_In = i.pc; RD1_In = i.rd1; RD2_In = i.rd2; extend_immed_In = i.imm; in_jump_addr = i.ja;
    RegDst_In = i.regdst; ALUSrc_In = i.alusrc; MemtoReg_In = i.memtoreg;
    RegWrite_In = i.regwrite; MemRead_In = i.memread; MemWrite_In = i.memwrite;
    Branch_In = i.branch; Jump_In = i.jump; ALUOp_In = i.aluop; operation_In = i.op;
    rt_In = i.rt; rd_In = i.rd;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Drive one instruction, hold it while stall_o is high, return after the capturing edge.
  task automatic send(input in_t i, input exp_t e, input int exp_stall);
    int  n = 0;
    bit  done = 0;
    apply(i);
    q.push_back(e);
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (stall_o) n++;
      else done = 1;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL stall_timeout: stall_o still high after %0d cycles", n);
    end else begin
      check("stall_cycles", n, exp_stall);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      bub_cnt = 0;
    end else if (RegWrite_Out | MemtoReg_Out | MemRead_Out | MemWrite_Out | Branch_Out | Jump_Out) begin
      if (q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_result: got res=%h wreg=%0d with empty scoreboard",
                 alu_result_Out, wreg_Out);
      end else begin
        exp_t e;
        e = q.pop_front();
        checks++;
        if (alu_result_Out !== e.res || wdata_Out !== e.wdata || branch_target_Out !== e.bt ||
            jump_addr_Out !== e.ja || wreg_Out !== e.wreg || zero_Out !== e.zero ||
            {RegWrite_Out, MemtoReg_Out, MemRead_Out, MemWrite_Out, Branch_Out, Jump_Out} !== e.ctl) begin
          failures++;
          $display("FAIL exmem: got res=%h wd=%h bt=%h ja=%h wreg=%0d z=%b ctl=%b expected res=%h wd=%h bt=%h ja=%h wreg=%0d z=%b ctl=%b",
                   alu_result_Out, wdata_Out, branch_target_Out, jump_addr_Out, wreg_Out, zero_Out,
                   {RegWrite_Out, MemtoReg_Out, MemRead_Out, MemWrite_Out, Branch_Out, Jump_Out},
                   e.res, e.wdata, e.bt, e.ja, e.wreg, e.zero, e.ctl);
        end
        if (e.bub >= 0) begin
          checks++;
          if (bub_cnt != e.bub) begin
            failures++;
            $display("FAIL bubbles: got %0d expected %0d before res=%h", bub_cnt, e.bub, e.res);
          end
        end
      end
      bub_cnt = 0;
    end else begin
      bub_cnt++;
    end
  end

  initial begin
    in_t i;
    rst = 1'b1;
    flush = 1'b0;
    i = in_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    apply(i);
    flush = 1'($urandom_range(0, 1));
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_data", alu_result_Out | wdata_Out | branch_target_Out | jump_addr_Out | 32'(wreg_Out), 32'h0);
    check("reset_ctl", {zero_Out, RegWrite_Out, MemtoReg_Out, MemRead_Out, MemWrite_Out, Branch_Out, Jump_Out}, 32'h0);
    check("reset_stall", {stall_o, mul_busy_o}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    flush = 1'b0;

    // R-type ADD wrapping to zero
    i = '0; i.aluop = 2'b10; i.op = 3'b010; i.regdst = 1; i.regwrite = 1;
    i.rd1 = 32'hFFFFFFFF; i.rd2 = 32'h1; i.rd = 9; i.rt = 2;
    send(i, mk(32'h0, 32'h1, 32'h0, 32'h0, 5'd9, 1'b1, 6'b100000, -1), 0);
    // lw
    i = '0; i.aluop = 2'b00; i.alusrc = 1; i.memread = 1; i.memtoreg = 1; i.regwrite = 1;
    i.rd1 = 32'h100; i.imm = 32'hFFFFFFFC; i.rt = 4; i.rd = 7; i.rd2 = 32'h55; i.pc = 32'h10;
    send(i, mk(32'hFC, 32'h55, 32'h0, 32'h0, 5'd4, 1'b0, 6'b111000, 0), 0);
    // sw
    i = '0; i.alusrc = 1; i.memwrite = 1; i.rd1 = 32'h200; i.imm = 32'h8;
    i.rd2 = 32'hDEADBEEF; i.pc = 32'h20; i.rt = 5;
    send(i, mk(32'h208, 32'hDEADBEEF, 32'h40, 32'h0, 5'd5, 1'b0, 6'b000100, 0), 0);
    // beq
    i = '0; i.aluop = 2'b01; i.branch = 1; i.rd1 = 32'h5; i.rd2 = 32'h5; i.pc = 32'h40;
    i.imm = 32'h3; i.rt = 6;
    send(i, mk(32'h0, 32'h5, 32'h4C, 32'h0, 5'd6, 1'b1, 6'b000010, 0), 0);
    // MUL 7*6
    i = '0; i.aluop = 2'b10; i.op = 3'b011; i.regdst = 1; i.regwrite = 1;
    i.rd1 = 32'h7; i.rd2 = 32'h6; i.rd = 16;
    send(i, mk(32'd42, 32'h6, 32'h0, 32'h0, 5'd16, 1'b0, 6'b100000, 32), 32);
    // back-to-back MUL 0xFFFFFFFF*2
    i.rd1 = 32'hFFFFFFFF; i.rd2 = 32'h2; i.rd = 17;
    send(i, mk(32'hFFFFFFFE, 32'h2, 32'h0, 32'h0, 5'd17, 1'b0, 6'b100000, 32), 32);
    // MUL with immediate operand B: 5*3
    i.alusrc = 1; i.rd1 = 32'h5; i.rd2 = 32'h64; i.imm = 32'h3; i.rd = 19;
    send(i, mk(32'd15, 32'h64, 32'hC, 32'h0, 5'd19, 1'b0, 6'b100000, 32), 32);
    // SUB
    i = '0; i.aluop = 2'b10; i.op = 3'b110; i.regdst = 1; i.regwrite = 1;
    i.rd1 = 32'h3; i.rd2 = 32'h5; i.rd = 10;
    send(i, mk(32'hFFFFFFFE, 32'h5, 32'h0, 32'h0, 5'd10, 1'b0, 6'b100000, 0), 0);
    // SLT signed both directions
    i.op = 3'b111; i.rd1 = 32'hFFFFFFFF; i.rd2 = 32'h1; i.rd = 11;
    send(i, mk(32'h1, 32'h1, 32'h0, 32'h0, 5'd11, 1'b0, 6'b100000, 0), 0);
    i.rd1 = 32'h1; i.rd2 = 32'hFFFFFFFF; i.rd = 12;
    send(i, mk(32'h0, 32'hFFFFFFFF, 32'h0, 32'h0, 5'd12, 1'b1, 6'b100000, 0), 0);
    // AND / OR / undefined funct
    i.op = 3'b000; i.rd1 = 32'hF0F0F0F0; i.rd2 = 32'hFF00FF00; i.rd = 13;
    send(i, mk(32'hF000F000, 32'hFF00FF00, 32'h0, 32'h0, 5'd13, 1'b0, 6'b100000, 0), 0);
    i.op = 3'b001; i.rd2 = 32'h0F000000; i.rd = 14;
    send(i, mk(32'hFFF0F0F0, 32'h0F000000, 32'h0, 32'h0, 5'd14, 1'b0, 6'b100000, 0), 0);
    i.op = 3'b100; i.rd1 = 32'h4; i.rd2 = 32'h4; i.rd = 18;
    send(i, mk(32'h8, 32'h4, 32'h0, 32'h0, 5'd18, 1'b0, 6'b100000, 0), 0);
    // jump, ALUOp 11 add
    i = '0; i.jump = 1; i.ja = 32'h1234; i.pc = 32'h50;
    send(i, mk(32'h0, 32'h0, 32'h50, 32'h1234, 5'd0, 1'b1, 6'b000001, 0), 0);
    i = '0; i.aluop = 2'b11; i.regwrite = 1; i.rd1 = 32'h2; i.rd2 = 32'h3; i.rt = 15;
    send(i, mk(32'h5, 32'h3, 32'h0, 32'h0, 5'd15, 1'b0, 6'b100000, 0), 0);

    // flush a MUL at busy counter 10, then an ADD completes in one cycle
    i = '0; i.aluop = 2'b10; i.op = 3'b011; i.regdst = 1; i.regwrite = 1;
    i.rd1 = 32'h3; i.rd2 = 32'h5; i.rd = 20;
    apply(i);
    @(negedge clk);
    check("issue_stall", stall_o, 1);
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    check("busy_before_flush", mul_busy_o, 1);
    check("stall_during_flush", stall_o, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    i = '0; i.aluop = 2'b10; i.op = 3'b010; i.regdst = 1; i.regwrite = 1;
    i.rd1 = 32'd10; i.rd2 = 32'd20; i.rd = 3;
    apply(i);
    q.push_back(mk(32'd30, 32'd20, 32'h0, 32'h0, 5'd3, 1'b0, 6'b100000, 12));
    @(negedge clk);
    check("busy_after_flush", mul_busy_o, 0);
    check("stall_after_flush", stall_o, 0);
    @(posedge clk); #1;
    i = '0;
    apply(i);
    repeat (2) @(posedge clk);
    check("scoreboard_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
